timing_decoder: RTL

- Receive-side counterpart of the LVDC timing generator.
- Samples the distributed timing bus (g1..g7 one-hot, a half-select, pa/pb/pc phase one-hot) once per bit-time strobe.
- Reconstructs bit time 0..13 and phase 0..2, checks every step against the legal successor, and reports lock and sequence errors.
- Feeds downstream decoding and diagnostic logic that must not trust a corrupted timing bus.

---
 rtl/timing_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/timing_decoder.sv
// Receive-side timing bus decoder: reconstructs bit time / phase, tracks lock, flags sequence errors.
// Optional macro TIMING_DECODER_PHASE_CHECK_EN: include phase in the successor check.
module timing_decoder #(
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned ERR_CNT_W      = 8,
  parameter int unsigned STROBE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tim_valid,
  input  logic [6:0]           g_in,
  input  logic                 a_in,
  input  logic [2:0]           p_in,
  input  logic                 clr_err,
  output logic [3:0]           bit_time,
  output logic [1:0]           phase,
  output logic                 locked,
  output logic                 frame_start,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned BT_W   = 4;
  localparam int unsigned PH_W   = 2;
  localparam int unsigned MCNT_W = 4;
  localparam int unsigned ICNT_W = 8;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(13);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                state_q;
  logic [BT_W-1:0]       exp_bt_q;
  logic [PH_W-1:0]       exp_ph_q;
  logic [MCNT_W-1:0]     mcnt_q;
  logic [ICNT_W-1:0]     icnt_q;
  logic [BT_W-1:0]       bit_time_q;
  logic [PH_W-1:0]       phase_q;
  logic                  locked_q;
  logic                  frame_start_q;
  logic                  seq_err_q;
  logic [ERR_CNT_W-1:0]  err_count_q;

  logic [2:0]            g_idx;
  logic                  legal_c;
  logic [BT_W-1:0]       samp_bt;
  logic [PH_W-1:0]       samp_ph;
  logic [BT_W-1:0]       succ_bt;
  logic [PH_W-1:0]       succ_ph;
  logic                  match_c;
  logic [MCNT_W-1:0]     mcnt_inc;
  logic [ICNT_W-1:0]     icnt_inc;
  logic                  lock_reached_c;
  logic                  timeout_c;
  logic                  err_det_c;

  // Sample decode: bit time = 2*k + half-select, phase = one-hot index
  always_comb begin
    g_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (g_in[k]) g_idx = 3'(k);
    end
    legal_c = $onehot(g_in) && $onehot(p_in);
    samp_bt = {g_idx, a_in};
    if (p_in[2])      samp_ph = PH_W'(2);
    else if (p_in[1]) samp_ph = PH_W'(1);
    else              samp_ph = PH_W'(0);
  end

  // Legal successor of the stored sample; bit time 13 wraps and advances phase C->A
  always_comb begin
    succ_bt = exp_bt_q + BT_W'(1);
    succ_ph = exp_ph_q;
    if (exp_bt_q == BT_LAST) begin
      succ_bt = '0;
      succ_ph = (exp_ph_q == PH_W'(2)) ? PH_W'(0) : exp_ph_q + PH_W'(1);
    end
`ifdef TIMING_DECODER_PHASE_CHECK_EN
    match_c = (samp_bt == succ_bt) && (samp_ph == succ_ph);
`else
    match_c = (samp_bt == succ_bt);
`endif
  end

  always_comb begin
    mcnt_inc       = mcnt_q + MCNT_W'(1);
    icnt_inc       = icnt_q + ICNT_W'(1);
    lock_reached_c = (mcnt_inc == MCNT_W'(LOCK_COUNT));
    timeout_c      = !tim_valid && (icnt_inc == ICNT_W'(STROBE_TIMEOUT));
    err_det_c      = (state_q == LOCKED) &&
                     ((tim_valid && !(legal_c && match_c)) || timeout_c);
  end

  // Lock FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      exp_bt_q      <= '0;
      exp_ph_q      <= '0;
      mcnt_q        <= '0;
      icnt_q        <= '0;
      bit_time_q    <= '0;
      phase_q       <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      frame_start_q <= 1'b0;
      seq_err_q     <= err_det_c;

      if (clr_err)
        err_count_q <= ERR_CNT_W'(err_det_c);
      else if (err_det_c && (err_count_q != {ERR_CNT_W{1'b1}}))
        err_count_q <= err_count_q + ERR_CNT_W'(1);

      case (state_q)
        HUNT: begin
          if (tim_valid && legal_c) begin
            exp_bt_q <= samp_bt;
            exp_ph_q <= samp_ph;
            mcnt_q   <= MCNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              bit_time_q <= samp_bt;
              phase_q    <= samp_ph;
              icnt_q     <= '0;
            end else begin
              state_q <= SYNC;
            end
          end
        end

        SYNC: begin
          if (tim_valid) begin
            if (!legal_c) begin
              state_q <= HUNT;
              mcnt_q  <= '0;
            end else begin
              exp_bt_q <= samp_bt;
              exp_ph_q <= samp_ph;
              if (match_c) begin
                mcnt_q <= mcnt_inc;
                if (lock_reached_c) begin
                  state_q    <= LOCKED;
                  locked_q   <= 1'b1;
                  bit_time_q <= samp_bt;
                  phase_q    <= samp_ph;
                  icnt_q     <= '0;
                end
              end else begin
                mcnt_q <= MCNT_W'(1);
              end
            end
          end
        end

        LOCKED: begin
          if (tim_valid) begin
            icnt_q <= '0;
            if (legal_c && match_c) begin
              exp_bt_q      <= samp_bt;
              exp_ph_q      <= samp_ph;
              bit_time_q    <= samp_bt;
              phase_q       <= samp_ph;
              frame_start_q <= (samp_bt == '0);
            end else if (legal_c) begin
              // Legal but out of sequence: restart acquisition from this sample
              exp_bt_q <= samp_bt;
              exp_ph_q <= samp_ph;
              mcnt_q   <= MCNT_W'(1);
              state_q  <= SYNC;
              locked_q <= 1'b0;
            end else begin
              mcnt_q   <= '0;
              state_q  <= HUNT;
              locked_q <= 1'b0;
            end
          end else if (timeout_c) begin
            icnt_q   <= '0;
            mcnt_q   <= '0;
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end else begin
            icnt_q <= icnt_inc;
          end
        end

        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
          mcnt_q   <= '0;
          icnt_q   <= '0;
        end
      endcase
    end
  end

  assign bit_time    = bit_time_q;
  assign phase       = phase_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule
